// File: rtl/fifo_write_arbiter.sv
// Round-robin write arbiter: N_REQ producers share one FIFO write port.
// Each grant moves up to MAX_BURST words, then priority rotates past the owner.
module fifo_write_arbiter #(
   parameter int WIDTH     = 16,
   parameter int N_REQ     = 4,
   parameter int MAX_BURST = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_REQ-1:0]              req,
   input  logic [N_REQ-1:0][WIDTH-1:0]   req_data,
   input  logic [N_REQ-1:0]              req_last,
   output logic [N_REQ-1:0]              ack,
   output logic                          fifo_write,
   output logic [WIDTH-1:0]              fifo_data_in,
   input  logic                          fifo_full,
   output logic [$clog2(N_REQ)-1:0]      grant_id,
   output logic                          busy
);

   localparam int IDW = $clog2(N_REQ);
   localparam int CW  = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   owner_q, owner_d;
   logic [CW-1:0]    burst_cnt_q, burst_cnt_d;
   logic [IDW-1:0]   next_owner;
   logic [IDW-1:0]   cand;
   logic             found;
   logic             xfer;
   logic             burst_done;

   // Search starts one past the current owner, so the owner itself is checked last.
   always_comb begin
      next_owner = owner_q;
      cand       = '0;
      found      = 1'b0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand = IDW'((int'(owner_q) + i) % N_REQ);
         if (!found && req[cand]) begin
            next_owner = cand;
            found      = 1'b1;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      burst_cnt_d  = burst_cnt_q;
      ack          = '0;
      fifo_write   = 1'b0;
      fifo_data_in = '0;
      xfer         = (state_q == GRANT) && req[owner_q] && !fifo_full;
      burst_done   = (int'(burst_cnt_q) + 1 == MAX_BURST);
      case (state_q)
         IDLE: begin
            if (found) begin
               owner_d     = next_owner;
               burst_cnt_d = '0;
               state_d     = GRANT;
            end
         end
         GRANT: begin
            fifo_write     = xfer;
            ack[owner_q]   = xfer;
            fifo_data_in   = req_data[owner_q];
            if (xfer)
               burst_cnt_d = burst_cnt_q + CW'(1);
            // A full FIFO holds the grant; only a withdrawn request ends it without a transfer.
            if ((xfer && (req_last[owner_q] || burst_done)) || !req[owner_q])
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= IDW'(N_REQ - 1);
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   assign busy     = (state_q == GRANT);
   assign grant_id = owner_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: producer queues and a FIFO model
// stepped once per clock, with hand-derived expectations for each scenario.
module tb_fifo_write_arbiter;

   localparam int W = 16;
   localparam int N = 4;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [N-1:0]       req = '0;
   logic [N-1:0][W-1:0] req_data = '0;
   logic [N-1:0]       req_last = '0;
   logic [N-1:0]       ack;
   logic               fifo_write;
   logic [W-1:0]       fifo_data_in;
   logic               fifo_full = 1'b0;
   logic [1:0]         grant_id;
   logic               busy;

   fifo_write_arbiter #(.WIDTH(W), .N_REQ(N), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
      .ack(ack), .fifo_write(fifo_write), .fifo_data_in(fifo_data_in),
      .fifo_full(fifo_full), .grant_id(grant_id), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [W:0]   pq [N][$];   // bit W = last-of-burst flag
   logic [W-1:0] fq [$];
   int           fdepth = 64;
   logic [N-1:0] en = '0;
   logic [N-1:0] s_ack;
   logic         s_wr;
   logic [W-1:0] s_din;
   logic [1:0]   s_gid;
   logic         s_busy;
   logic [W:0]   tmp;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_inputs();
      for (int i = 0; i < N; i++) begin
         if (en[i] && pq[i].size() > 0) begin
            req[i]      = 1'b1;
            req_data[i] = pq[i][0][W-1:0];
            req_last[i] = pq[i][0][W];
         end else begin
            req[i]      = 1'b0;
            req_data[i] = '0;
            req_last[i] = 1'b0;
         end
      end
      fifo_full = (fq.size() >= fdepth);
   endtask

   // One clock: drive at posedge+1, sample at posedge+2, commit at the edge.
   task automatic tick(input bit rd);
      set_inputs();
      #1;
      s_ack = ack; s_wr = fifo_write; s_din = fifo_data_in;
      s_gid = grant_id; s_busy = busy;
      @(posedge clk);
      if (s_wr) fq.push_back(s_din);
      if (rd && fq.size() > 0) tmp = {1'b0, fq.pop_front()};
      for (int i = 0; i < N; i++)
         if (s_ack[i]) tmp = pq[i].pop_front();
      #1;
   endtask

   task automatic do_reset();
      en = '0;
      for (int i = 0; i < N; i++) pq[i].delete();
      fq.delete();
      set_inputs();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      // Reset state
      @(posedge clk); @(posedge clk); #2;
      check("rst_ack", ack, 0);
      check("rst_wr", fifo_write, 0);
      check("rst_din", fifo_data_in, 0);
      check("rst_busy", busy, 0);
      check("rst_gid", grant_id, 3);

      // Round-robin and data integrity: 4 x 8 tagged words
      do_reset();
      fdepth = 64;
      for (int i = 0; i < N; i++)
         for (int s = 0; s < 8; s++) pq[i].push_back({1'b0, 16'((i << 8) | s)});
      en = 4'hF;
      begin
         int wr_total = 0;
         for (int t = 0; t <= 40; t++) begin
            tick(0);
            if (t < 20) check($sformatf("rr_wr_t%0d", t), s_wr, (t % 5) != 0);
            if (s_wr) begin
               wr_total++;
               check($sformatf("rr_gid_t%0d", t), s_gid, (t / 5) % 4);
            end
            if (t == 19) check("rr_writes_in_20", wr_total, 16);
         end
         check("rr_total", wr_total, 32);
         check("rr_idle_end", s_busy, 0);
      end
      check("di_count", fq.size(), 32);
      for (int k = 0; k < 32 && k < fq.size(); k++)
         check($sformatf("di_word%0d", k), fq[k],
               (((k % 16) / 4) << 8) | ((k / 16) * 4 + (k % 4)));

      // Reset mid-burst of requester 1
      do_reset();
      for (int s = 0; s < 8; s++) pq[1].push_back({1'b0, 16'((1 << 8) | s)});
      en = 4'b0010;
      tick(0); check("mb_idle", s_busy, 0);
      tick(0); check("mb_w0", s_din, 16'h0100);
      tick(0); check("mb_w1", s_din, 16'h0101);
      set_inputs(); #1;
      check("mb_pre_ack", ack, 4'b0010);
      check("mb_pre_wr", fifo_write, 1);
      rst = 1'b1; #1;
      check("mb_rst_ack", ack, 0);
      check("mb_rst_wr", fifo_write, 0);
      check("mb_rst_gid", grant_id, 3);
      check("mb_rst_busy", busy, 0);
      check("mb_rst_din", fifo_data_in, 0);
      @(posedge clk); #1; rst = 1'b0;
      pq[0].push_back({1'b0, 16'h0000}); pq[0].push_back({1'b0, 16'h0001});
      en = 4'b0011;
      tick(0); check("mb_post_idle", s_busy, 0);
      tick(0);
      check("mb_post_gid", s_gid, 0);
      check("mb_post_ack", s_ack, 4'b0001);

      // Early termination on req_last, then re-grant
      do_reset();
      pq[2].push_back({1'b0, 16'h00A1}); pq[2].push_back({1'b1, 16'h00A2});
      pq[2].push_back({1'b0, 16'h00A3}); pq[2].push_back({1'b0, 16'h00A4});
      en = 4'b0100;
      tick(0);
      tick(0); check("et_w0", s_din, 16'h00A1); check("et_ack0", s_ack, 4'b0100);
      tick(0); check("et_w1", s_din, 16'h00A2);
      tick(0); check("et_idle_wr", s_wr, 0); check("et_idle_busy", s_busy, 0);
      tick(0); check("et_regrant_wr", s_wr, 1); check("et_regrant_din", s_din, 16'h00A3);
      check("et_regrant_gid", s_gid, 2);

      // FIFO full back-pressure
      do_reset();
      fdepth = 16;
      for (int k = 0; k < 15; k++) fq.push_back(16'hEE00 | 16'(k));
      for (int s = 0; s < 6; s++) pq[0].push_back({1'b0, 16'(16'h0010 + s)});
      en = 4'b0001;
      tick(0);
      tick(0); check("ff_w0", s_din, 16'h0010); check("ff_w0_wr", s_wr, 1);
      tick(0); check("ff_full_wr0", s_wr, 0); check("ff_full_ack0", s_ack, 0);
      check("ff_full_busy", s_busy, 1);
      tick(0); check("ff_full_wr1", s_wr, 0);
      tick(1); check("ff_full_wr2", s_wr, 0);
      tick(1); check("ff_w1_wr", s_wr, 1); check("ff_w1", s_din, 16'h0011);
      tick(1); check("ff_w2", s_din, 16'h0012);
      tick(1); check("ff_w3", s_din, 16'h0013);
      tick(1); check("ff_end_busy", s_busy, 0); check("ff_end_wr", s_wr, 0);

      // Owner withdraws before any transfer
      do_reset();
      fdepth = 64;
      for (int i = 0; i < N; i++)
         for (int s = 0; s < 4; s++) pq[i].push_back({1'b0, 16'((i << 8) | s)});
      en = 4'b1000;
      tick(0); check("ow_idle", s_busy, 0);
      en = 4'b0000;
      tick(0);
      check("ow_gid", s_gid, 3); check("ow_busy", s_busy, 1);
      check("ow_wr", s_wr, 0); check("ow_ack", s_ack, 0);
      en = 4'b1111;
      tick(0); check("ow_back_idle", s_busy, 0);
      tick(0); check("ow_next_gid", s_gid, 0); check("ow_next_ack", s_ack, 4'b0001);
      check("ow_fifo_writes", fq.size(), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
